// File: rtl/ss_scan_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ss_scan_driver_if : glyph load handshake and display pin bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface ss_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
);
  logic [5*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    load_ack;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [7:0]              segment_n;

  modport master (
    output digits_in, dp_in, load, brightness,
    input  load_ack, frame_start, anode_n, segment_n
  );

  modport slave (
    input  digits_in, dp_in, load, brightness,
    output load_ack, frame_start, anode_n, segment_n
  );
endinterface
`default_nettype wire

// File: rtl/ss_scan_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ss_scan_driver : N-digit multiplexed 7-segment scanner with frame-synced
// loads and optional leading-zero blanking. Define BRIGHTNESS_PWM_EN for PWM.
// Rev 1.0
// ---------------------------------------------------------------------------
module ss_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 131072,
  parameter int LZ_BLANK   = 0,
  parameter int BRIGHT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  ss_scan_driver_if.slave  bus
);

  localparam int                PRE_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                IDX_W       = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4:0]        GLYPH_BLANK = 5'd16;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:  decode = 7'h3F;
      5'd1:  decode = 7'h06;
      5'd2:  decode = 7'h5B;
      5'd3:  decode = 7'h4F;
      5'd4:  decode = 7'h66;
      5'd5:  decode = 7'h6D;
      5'd6:  decode = 7'h7D;
      5'd7:  decode = 7'h07;
      5'd8:  decode = 7'h7F;
      5'd9:  decode = 7'h6F;
      5'd10: decode = 7'h77;
      5'd11: decode = 7'h7C;
      5'd12: decode = 7'h39;
      5'd13: decode = 7'h5E;
      5'd14: decode = 7'h79;
      5'd15: decode = 7'h71;
      5'd17: decode = 7'h40;
      5'd18: decode = 7'h76;
      5'd19: decode = 7'h38;
      5'd20: decode = 7'h73;
      default: decode = 7'h00;
    endcase
  endfunction

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        index;
  logic [5*NUM_DIGITS-1:0] disp_code;
  logic [5*NUM_DIGITS-1:0] pend_code;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic                    ack_pulse;
  logic                    frame_pulse;
  logic [NUM_DIGITS-1:0]   anode_drive;
  logic [7:0]              seg_drive;

  logic                    tick;
  logic                    boundary;
  logic [4:0]              cur_code;
  logic                    cur_dp;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic                    dark;

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (index == IDX_LAST);

  generate
    if (LZ_BLANK != 0) begin : g_lz_blank
      // A digit is blanked only while it and every digit to its left read 0.
      always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
          zero_run     = zero_run && (disp_code[5*k +: 5] == 5'd0);
          lead_zero[k] = zero_run;
        end
      end
    end else begin : g_no_lz_blank
      assign lead_zero = '0;
    end
  endgenerate

`ifdef BRIGHTNESS_PWM_EN
  logic [BRIGHT_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
  end

  assign dark = (pwm_cnt >= bus.brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign dark = 1'b0;
`endif

  always_comb begin
    cur_code   = disp_code[5*int'(index) +: 5];
    cur_dp     = disp_dp[index];
    glyph      = lead_zero[index] ? 7'h00 : decode(cur_code);
    anode_next = dark ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << index);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      index       <= '0;
      disp_code   <= {NUM_DIGITS{GLYPH_BLANK}};
      pend_code   <= {NUM_DIGITS{GLYPH_BLANK}};
      disp_dp     <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      ack_pulse   <= 1'b0;
      frame_pulse <= 1'b0;
      anode_drive <= {NUM_DIGITS{1'b1}};
      seg_drive   <= 8'hFF;
    end else begin
      prescaler   <= tick ? '0 : prescaler + PRE_W'(1);
      if (tick) index <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
      frame_pulse <= boundary;
      ack_pulse   <= 1'b0;
      // A load landing exactly on the boundary goes straight to the display.
      if (boundary) begin
        if (bus.load) begin
          disp_code  <= bus.digits_in;
          disp_dp    <= bus.dp_in;
          pend_valid <= 1'b0;
          ack_pulse  <= 1'b1;
        end else if (pend_valid) begin
          disp_code  <= pend_code;
          disp_dp    <= pend_dp;
          pend_valid <= 1'b0;
          ack_pulse  <= 1'b1;
        end
      end else if (bus.load) begin
        pend_code  <= bus.digits_in;
        pend_dp    <= bus.dp_in;
        pend_valid <= 1'b1;
      end
      anode_drive <= anode_next;
      seg_drive   <= {~cur_dp, ~glyph};
    end
  end

  assign bus.anode_n     = anode_drive;
  assign bus.segment_n   = seg_drive;
  assign bus.load_ack    = ack_pulse;
  assign bus.frame_start = frame_pulse;

endmodule
`default_nettype wire

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
- Parametrised multiplexed seven-segment driver. Generalises the fixed 8-digit scanner to N digits, with:
  - a configurable scan rate;
  - per-digit decimal points;
  - a frame-synchronous load handshake, so glyph updates never tear mid-frame;
  - optional leading-zero blanking;
  - optional brightness PWM.
- Sits between application counters/registers and board anode/segment pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- SCAN_DIV, 131072, clk cycles per digit slot (>=2); 100 MHz/131072 = 763 Hz slot rate.
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 never blanked).
- BRIGHT_W, 4, width of the brightness input (used only with BRIGHTNESS_PWM_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- digits_in  in  5*NUM_DIGITS  glyph codes; digit k = bits [5k+4:5k]; digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- load  in  1  single-cycle strobe; captures digits_in/dp_in.
- brightness  in  BRIGHT_W  duty level, 0 = dark.
- load_ack  out  1  one-cycle pulse when loaded data becomes visible.
- frame_start  out  1  one-cycle pulse when the slot index wraps to 0.
- anode_n  out  NUM_DIGITS  digit enables, active low.
- segment_n  out  8  [6:0] = g..a, [7] = dp; active low.

Behaviour:
- Reset state:
  - prescaler, slot index, pwm counter = 0;
  - display and pending registers = glyph 16 (blank), dp = 0;
  - pending_valid = 0;
  - anode_n = all 1, segment_n = 8'hFF, load_ack = 0, frame_start = 0.
- Reset asserted mid-frame forces this state on the next edge. A pending load is discarded.
- Prescaler:
  - counts 0..SCAN_DIV-1 and wraps;
  - tick = (prescaler == SCAN_DIV-1);
  - on tick, index advances; it wraps from NUM_DIGITS-1 to 0.
- Frame boundary = tick while index == NUM_DIGITS-1. At the boundary:
  - frame_start pulses in the next cycle;
  - if pending_valid: display <= pending, pending_valid <= 0, load_ack pulses in the same cycle as frame_start.
- Load handshake:
  - load = 1 captures the inputs into pending and sets pending_valid.
  - A second load before the boundary overwrites pending; latest data wins, and there is one ack.
  - A load in the boundary cycle itself is applied at that boundary (bypasses pending); ack follows next cycle.
- Decoder, 5-bit code:
  - 0..15 = hex 0-9, A, b, C, d, E, F;
  - 16 = blank; 17 = '-'; 18 = 'H'; 19 = 'L'; 20 = 'P'; 21..31 = blank.
  - Active-high segment pattern, inverted at output.
- Outputs are registered from the index/display registers, giving 1-cycle latency after an index change:
  - anode_n = ~(1 << index);
  - segment_n = {~dp[index], ~seg[index]}.
- Exactly one anode is low at any time outside reset and outside the PWM off-phase. There are no glitches between slots.
- LZ_BLANK = 1:
  - digit k > 0 is blanked (segments off, dp still honoured) when digit k and all higher digits hold code 0;
  - evaluated on the display register, not on digits_in.

Optional Feature:
- Macro: BRIGHTNESS_PWM_EN.
- Defined:
  - a free-running BRIGHT_W-bit pwm counter increments every clk;
  - anode_n forced all 1 when pwm_cnt >= brightness;
  - brightness 0 = fully dark; max value = (2^BRIGHT_W-1)/2^BRIGHT_W duty;
  - segment_n is unaffected.
- Not defined: brightness is ignored, the pwm counter is absent, and the active anode is always low.

Test Plan:
All cases use NUM_DIGITS=4, SCAN_DIV=4.
- Reset, then release; hold 20 cycles with no load -> anode_n sequence 1110, 1101, 1011, 0111 with each slot 4 cycles; segment_n = 8'hFF throughout; frame_start pulses every 16 cycles.
- load with digits 3,2,1,0 = 0x1,0xA,0x5,0x0 and dp_in = 4'b0010 mid-frame -> no change until the boundary; at the boundary load_ack = 1 and frame_start = 1 in the same cycle. Next frame must show:
  - slot0 segment_n = 8'hC0;
  - slot1 segment_n = 8'h12 (5 with dp);
  - slot2 segment_n = 8'h88 ('A');
  - slot3 segment_n = 8'hF9 ('1').
- Two loads in one frame, codes 0x3 then 0x7 in digit 0 -> single load_ack; digit 0 shows 8'hF8 ('7').
- LZ_BLANK=1 with digits = 0,0,4,0 (digit 3..0) -> digits 3 and 2 blank (8'hFF); digit 1 = 8'h99; digit 0 = 8'hC0.
- Reset asserted in the cycle after a load, before the boundary -> no load_ack ever; display stays blank; anode_n = 4'hF during reset.
- With BRIGHTNESS_PWM_EN, brightness = 4 (BRIGHT_W=4) -> the active anode is low for exactly 4 of every 16 cycles. brightness = 0 -> anode_n stays 4'hF.
